// File: rtl/irq_pkg.sv
// Shared types and constants for the MMC3-family scanline IRQ engine.
package irq_pkg;

   typedef enum logic [1:0] {
      IRQ_MMC3B = 2'd0,
      IRQ_MMC3A = 2'd1,
      IRQ_ACC   = 2'd2,
      IRQ_OFF   = 2'd3
   } irq_mode_e;

   localparam logic [3:0] REG_LATCH   = 4'hC;
   localparam logic [3:0] REG_RELOAD  = 4'hD;
   localparam logic [3:0] REG_DISABLE = 4'hE;
   localparam logic [3:0] REG_ENABLE  = 4'hF;

   localparam logic [7:0] SST_LATCH = 8'd16;
   localparam logic [7:0] SST_COUNT = 8'd17;
   localparam logic [7:0] SST_FLAGS = 8'd18;
   localparam logic [7:0] SST_PRESC = 8'd19;
   localparam logic [7:0] SST_FILT  = 8'd20;

   typedef struct packed {
      logic       act;
      logic       we_reg;
      logic [7:0] addr;
      logic [7:0] din;
   } SSTBus;

   // This block owns save-state slots 16..23.
   function automatic logic sst_hit(input logic [7:0] a);
      return a[7:3] == 5'b00010;
   endfunction

endpackage

// File: rtl/irq_mmc3_gen_if.sv
// CPU register-write strobe and save-state bus shared with the mapper core.
interface irq_mmc3_gen_if;
   import irq_pkg::*;

   logic       decode_en;
   logic [3:0] reg_addr;
   logic [7:0] cpu_data;
   SSTBus      sst;
   logic       sst_ce;
   logic [7:0] sst_do;

   modport master (output decode_en, reg_addr, cpu_data, sst, input sst_ce, sst_do);
   modport slave  (input decode_en, reg_addr, cpu_data, sst, output sst_ce, sst_do);

endinterface

// File: rtl/irq_a12_evt.sv
// A12/M2 edge detection, M2-timed A12 low filter and Acclaim prescaler.
// Emits a single-clk counter event for the currently selected mode.
module irq_a12_evt import irq_pkg::*; #(
   parameter  int A12_FILT = 3,
   parameter  int ACC_DIV  = 8,
   localparam int FW       = $clog2(A12_FILT + 1),
   localparam int PW       = $clog2(ACC_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  irq_mode_e     mode_i,
   input  logic          hold_i,
   input  logic          presc_clr_i,
   input  logic          presc_ld_i,
   input  logic [PW-1:0] presc_val_i,
   input  logic          filt_ld_i,
   input  logic [FW-1:0] filt_val_i,
   input  logic          cpu_m2_i,
   input  logic          ppu_a12_i,
   output logic          evt_o,
   output logic [PW-1:0] presc_o,
   output logic [FW-1:0] filt_o
);

   localparam logic [FW-1:0] FILT_SAT  = FW'(A12_FILT);
   localparam logic [PW-1:0] PRESC_TOP = PW'(ACC_DIV - 1);

   logic          a12_q, m2_q;
   irq_mode_e     mode_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [FW-1:0] filt_q, filt_d;
   logic          a12_rise, a12_fall, m2_fall, mmc3, acc, mode_chg;

   assign a12_rise = ppu_a12_i & ~a12_q;
   assign a12_fall = ~ppu_a12_i & a12_q;
   assign m2_fall  = ~cpu_m2_i & m2_q;
   assign mmc3     = (mode_i == IRQ_MMC3B) || (mode_i == IRQ_MMC3A);
   assign acc      = (mode_i == IRQ_ACC);
   assign mode_chg = (mode_i != mode_q);

   // The filter is judged on its value before this edge's clear.
   assign evt_o = ~hold_i & ((mmc3 & a12_rise & (filt_q >= FILT_SAT)) |
                             (acc & a12_fall & (presc_q == PRESC_TOP)));

   always_comb begin
      presc_d = presc_q;
      if (presc_ld_i)
         presc_d = presc_val_i;
      else if (mode_chg || presc_clr_i)
         presc_d = '0;
      else if (!hold_i && acc && a12_fall)
         presc_d = (presc_q == PRESC_TOP) ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      filt_d = filt_q;
      if (filt_ld_i)
         filt_d = filt_val_i;
      else if (mode_chg)
         filt_d = '0;
      else if (hold_i)
         filt_d = filt_q;
      else if (ppu_a12_i)
         filt_d = '0;
      else if (m2_fall && (filt_q < FILT_SAT))
         filt_d = filt_q + FW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a12_q   <= 1'b0;
         m2_q    <= 1'b0;
         mode_q  <= IRQ_MMC3B;
         presc_q <= '0;
         filt_q  <= FILT_SAT;
      end else begin
         a12_q   <= ppu_a12_i;
         m2_q    <= cpu_m2_i;
         mode_q  <= mode_i;
         presc_q <= presc_d;
         filt_q  <= filt_d;
      end
   end

   assign presc_o = presc_q;
   assign filt_o  = filt_q;

endmodule

// File: rtl/irq_mmc3_gen.sv
// Runtime-selectable MMC3 rev A / rev B / Acclaim scanline IRQ core with
// register file, reload/counter logic and save-state access.
module irq_mmc3_gen import irq_pkg::*; #(
   parameter int CNT_W    = 8,
   parameter int A12_FILT = 3,
   parameter int ACC_DIV  = 8
) (
   input  logic         clk,
   input  logic         map_rst_n,
   input  logic [1:0]   mode,
   input  logic         cpu_m2,
   input  logic         ppu_a12,
   output logic         irq,
   irq_mmc3_gen_if.slave bus
);

   localparam int FW = $clog2(A12_FILT + 1);
   localparam int PW = $clog2(ACC_DIV);

   irq_mode_e        md;
   logic [CNT_W-1:0] latch_q, latch_d, cnt_q, cnt_d;
   logic             rel_q, rel_d, en_q, en_d, irq_q, irq_d;
   logic             evt, cpu_wr, sst_wr;
   logic [PW-1:0]    presc;
   logic [FW-1:0]    filt;

   assign md          = irq_mode_e'(mode);
   assign bus.sst_ce  = sst_hit(bus.sst.addr);
   assign cpu_wr      = bus.decode_en & ~bus.sst.act;
   assign sst_wr      = bus.sst.act & bus.sst.we_reg & bus.sst_ce;

   irq_a12_evt #(.A12_FILT(A12_FILT), .ACC_DIV(ACC_DIV)) u_evt (
      .clk         (clk),
      .rst_n       (map_rst_n),
      .mode_i      (md),
      .hold_i      (bus.sst.act),
      .presc_clr_i (cpu_wr && (bus.reg_addr == REG_RELOAD)),
      .presc_ld_i  (sst_wr && (bus.sst.addr == SST_PRESC)),
      .presc_val_i (bus.sst.din[PW-1:0]),
      .filt_ld_i   (sst_wr && (bus.sst.addr == SST_FILT)),
      .filt_val_i  (bus.sst.din[FW-1:0]),
      .cpu_m2_i    (cpu_m2),
      .ppu_a12_i   (ppu_a12),
      .evt_o       (evt),
      .presc_o     (presc),
      .filt_o      (filt)
   );

   // Event first, then writes: a same-cycle 0xD/0xE overrides the event result,
   // while 0xC only affects later reloads.
   always_comb begin
      latch_d = latch_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      en_d    = en_q;
      irq_d   = irq_q;
      if (evt) begin
         if ((cnt_q == '0) || rel_q) begin
            cnt_d = latch_q;
            rel_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
         if (en_q && (cnt_d == '0) && ((md != IRQ_MMC3A) || (cnt_q != '0) || rel_q))
            irq_d = 1'b1;
      end
      if (cpu_wr) begin
         case (bus.reg_addr)
            REG_LATCH:   latch_d = CNT_W'(bus.cpu_data);
            REG_RELOAD:  begin cnt_d = '0; rel_d = 1'b1; end
            REG_DISABLE: begin en_d = 1'b0; irq_d = 1'b0; end
            REG_ENABLE:  en_d = 1'b1;
            default: ;
         endcase
      end
      if (sst_wr) begin
         case (bus.sst.addr)
            SST_LATCH: latch_d = CNT_W'(bus.sst.din);
            SST_COUNT: cnt_d   = CNT_W'(bus.sst.din);
            SST_FLAGS: {en_d, rel_d, irq_d} = bus.sst.din[2:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n) begin
         latch_q <= '0;
         cnt_q   <= '0;
         rel_q   <= 1'b0;
         en_q    <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         en_q    <= en_d;
         irq_q   <= irq_d;
      end
   end

   assign irq = irq_q;

   always_comb begin
      bus.sst_do = 8'h00;
      if (bus.sst_ce) begin
         case (bus.sst.addr)
            SST_LATCH: bus.sst_do = latch_q[7:0];
            SST_COUNT: bus.sst_do = cnt_q[7:0];
            SST_FLAGS: bus.sst_do = {5'b0, en_q, rel_q, irq_q};
            SST_PRESC: bus.sst_do = 8'(presc);
            SST_FILT:  bus.sst_do = 8'(filt);
            default:   bus.sst_do = 8'hFF;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_mmc3_gen.sv
// Self-checking bench: transaction-level model of the scanline counter
// driven by A12 pulses, Acclaim fall counts and CPU/save-state writes.
module tb_irq_mmc3_gen;
   import irq_pkg::*;

   localparam int FILT = 3;
   localparam int DIV  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       m2 = 1'b0;
   logic       a12 = 1'b0;
   logic       irq;

   irq_mmc3_gen_if bus();

   irq_mmc3_gen #(.CNT_W(8), .A12_FILT(FILT), .ACC_DIV(DIV)) dut (
      .clk       (clk),
      .map_rst_n (rst_n),
      .mode      (mode),
      .cpu_m2    (m2),
      .ppu_a12   (a12),
      .irq       (irq),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference state
   int m_latch, m_cnt, m_low, m_fc;
   bit m_rel, m_en, m_irq;

   task automatic m_reset();
      m_latch = 0; m_cnt = 0; m_rel = 0; m_en = 0; m_irq = 0;
      m_low = FILT; m_fc = 0;
   endtask

   task automatic m_event();
      int old;
      bit was_rel;
      old = m_cnt;
      was_rel = m_rel;
      if (old == 0 || was_rel) begin m_cnt = m_latch; m_rel = 0; end
      else m_cnt = old - 1;
      if (m_en && m_cnt == 0 && (mode != 2'd1 || old != 0 || was_rel)) m_irq = 1;
   endtask

   task automatic m_write(input logic [3:0] a, input logic [7:0] d);
      case (a)
         4'hC: m_latch = d;
         4'hD: begin m_cnt = 0; m_rel = 1; m_fc = 0; end
         4'hE: begin m_en = 0; m_irq = 0; end
         4'hF: m_en = 1;
         default: ;
      endcase
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
      bus.decode_en = 1'b1; bus.reg_addr = a; bus.cpu_data = d;
      cyc();
      bus.decode_en = 1'b0;
      m_write(a, d);
   endtask

   task automatic m2_falls(input int n);
      repeat (n) begin
         m2 = 1'b1; cyc();
         m2 = 1'b0; cyc();
         if (!a12 && m_low < FILT) m_low++;
      end
   endtask

   task automatic a12_up(input bit with_wr, input logic [3:0] a, input logic [7:0] d);
      bit rose;
      rose = !a12;
      a12 = 1'b1;
      if (with_wr) begin bus.decode_en = 1'b1; bus.reg_addr = a; bus.cpu_data = d; end
      cyc();
      bus.decode_en = 1'b0;
      if (rose && mode <= 2'd1 && m_low >= FILT) m_event();
      m_low = 0;
      if (with_wr) m_write(a, d);
   endtask

   task automatic a12_down();
      bit fell;
      fell = a12;
      a12 = 1'b0;
      cyc();
      if (fell && mode == 2'd2) begin
         m_fc++;
         if (m_fc == DIV) begin m_fc = 0; m_event(); end
      end
   endtask

   task automatic scanline(input int falls);
      a12_down();
      m2_falls(falls);
      a12_up(0, 4'h0, 8'h00);
   endtask

   task automatic set_mode(input logic [1:0] m);
      if (m != mode) begin
         mode = m;
         cyc();
         m_low = 0;
         m_fc = 0;
      end
   endtask

   task automatic sst_rd(input logic [7:0] a, output logic [7:0] d);
      bus.sst.addr = a;
      #1;
      d = bus.sst_do;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      sst_rd(SST_LATCH, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_latch: got %0d expected 0", v); end
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", v); end
      sst_rd(SST_FLAGS, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_flags: got %0h expected 0", v); end
      sst_rd(SST_PRESC, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_presc: got %0d expected 0", v); end
      sst_rd(SST_FILT, v);
      checks++; if (v !== 8'(FILT)) begin errors++; $display("FAIL reset_filt: got %0d expected %0d", v, FILT); end
      sst_rd(8'd22, v);
      checks++; if (v !== 8'hFF) begin errors++; $display("FAIL sst_unused: got %0h expected ff", v); end
      bus.sst.addr = 8'd24; #1;
      checks++; if (bus.sst_ce !== 1'b0) begin errors++; $display("FAIL sst_ce_out: got %b expected 0", bus.sst_ce); end
   endtask

   task automatic test_revb();
      logic [7:0] v;
      set_mode(2'd0);
      cpu_wr(4'hC, 8'd3); cpu_wr(4'hD, 8'd0); cpu_wr(4'hF, 8'd0);
      for (int i = 0; i < 4; i++) begin
         scanline(3);
         sst_rd(SST_COUNT, v);
         checks++; if (v !== 8'(3 - i)) begin errors++; $display("FAIL revb_cnt[%0d]: got %0d expected %0d", i, v, 3 - i); end
         checks++; if (irq !== m_irq) begin errors++; $display("FAIL revb_irq[%0d]: got %b expected %b", i, irq, m_irq); end
      end
      cpu_wr(4'hE, 8'd0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL revb_ack: got %b expected 0", irq); end
   endtask

   task automatic test_latch0();
      for (int md = 0; md < 2; md++) begin
         set_mode(2'(md));
         cpu_wr(4'hC, 8'd0); cpu_wr(4'hD, 8'd0); cpu_wr(4'hF, 8'd0);
         for (int i = 0; i < 3; i++) begin
            scanline(3);
            checks++;
            if (irq !== m_irq) begin errors++; $display("FAIL latch0_m%0d[%0d]: got %b expected %b", md, i, irq, m_irq); end
            cpu_wr(4'hE, 8'd0); cpu_wr(4'hF, 8'd0);
         end
      end
   endtask

   task automatic test_filter();
      logic [7:0] v;
      set_mode(2'd0);
      cpu_wr(4'hC, 8'd5); cpu_wr(4'hD, 8'd0); cpu_wr(4'hF, 8'd0);
      scanline(3);
      scanline(2);
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL filter_short: got %0d expected %0d", v, m_cnt); end
      scanline(3);
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL filter_ok: got %0d expected %0d", v, m_cnt); end
      m2_falls(3);
      scanline(0);
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL filter_high_m2: got %0d expected %0d", v, m_cnt); end
   endtask

   task automatic test_acclaim();
      logic [7:0] v;
      set_mode(2'd2);
      cpu_wr(4'hC, 8'd1); cpu_wr(4'hD, 8'd0); cpu_wr(4'hF, 8'd0);
      for (int i = 1; i <= 16; i++) begin
         a12_up(0, 4'h0, 8'h00);
         a12_down();
         if (i == 7 || i == 8 || i == 16) begin
            sst_rd(SST_COUNT, v);
            checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL acc_cnt[%0d]: got %0d expected %0d", i, v, m_cnt); end
            sst_rd(SST_PRESC, v);
            checks++; if (v !== 8'(m_fc)) begin errors++; $display("FAIL acc_presc[%0d]: got %0d expected %0d", i, v, m_fc); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL acc_irq[%0d]: got %b expected %b", i, irq, m_irq); end
         end
      end
   endtask

   task automatic test_conflicts();
      logic [7:0] v;
      set_mode(2'd0);
      cpu_wr(4'hC, 8'd1); cpu_wr(4'hD, 8'd0); cpu_wr(4'hF, 8'd0);
      scanline(3);
      a12_down(); m2_falls(3); a12_up(1, 4'hE, 8'h00);
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL ack_evt_cnt: got %0d expected %0d", v, m_cnt); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_evt_irq: got %b expected 0", irq); end
      cpu_wr(4'hF, 8'd0);
      a12_down(); m2_falls(3); a12_up(1, 4'hD, 8'h00);
      sst_rd(SST_FLAGS, v);
      checks++; if (v !== {5'b0, m_en, m_rel, m_irq}) begin errors++; $display("FAIL rld_evt_flags: got %0h expected %0h", v, {5'b0, m_en, m_rel, m_irq}); end
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL rld_evt_cnt: got %0d expected %0d", v, m_cnt); end
      a12_down(); m2_falls(3); a12_up(1, 4'hC, 8'd7);
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL lat_evt_cnt: got %0d expected %0d", v, m_cnt); end
      sst_rd(SST_LATCH, v);
      checks++; if (v !== 8'(m_latch)) begin errors++; $display("FAIL lat_evt_latch: got %0d expected %0d", v, m_latch); end
   endtask

   task automatic test_random();
      logic [7:0] v;
      int r;
      for (int i = 0; i < 80; i++) begin
         if (i % 16 == 0) set_mode(2'($urandom_range(0, 3)));
         r = $urandom_range(0, 9);
         if (r < 3) cpu_wr(4'($urandom_range(8, 15)), 8'($urandom_range(0, 3)));
         else if (r < 7) scanline($urandom_range(0, 4));
         else begin a12_up(0, 4'h0, 8'h00); a12_down(); end
         sst_rd(SST_COUNT, v);
         checks++; if (v !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, v, m_cnt); end
         sst_rd(SST_FLAGS, v);
         checks++; if (v !== {5'b0, m_en, m_rel, m_irq}) begin errors++; $display("FAIL rnd_flags[%0d]: got %0h expected %0h", i, v, {5'b0, m_en, m_rel, m_irq}); end
         checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq[%0d]: got %b expected %b", i, irq, m_irq); end
      end
   endtask

   task automatic test_sst_reset();
      logic [7:0] v;
      logic [7:0] wv [5];
      wv = '{8'h5A, 8'h21, 8'h05, 8'h05, 8'h02};
      set_mode(2'd0);
      a12_down();
      bus.sst.act = 1'b1; bus.sst.we_reg = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.sst.addr = 8'(16 + i); bus.sst.din = wv[i];
         cyc();
      end
      bus.sst.we_reg = 1'b0;
      cpu_wr(4'hE, 8'd0);
      m_en = 1; m_irq = 1;
      for (int i = 0; i < 5; i++) begin
         sst_rd(8'(16 + i), v);
         checks++; if (v !== wv[i]) begin errors++; $display("FAIL sst_rb[%0d]: got %0h expected %0h", 16 + i, v, wv[i]); end
      end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sst_irq_hold: got %b expected 1", irq); end
      bus.sst.act = 1'b0;
      cyc();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_async_irq: got %b expected 0", irq); end
      sst_rd(SST_COUNT, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", v); end
      sst_rd(SST_FLAGS, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_flags: got %0h expected 0", v); end
      sst_rd(SST_FILT, v);
      checks++; if (v !== 8'(FILT)) begin errors++; $display("FAIL rst_filt: got %0d expected %0d", v, FILT); end
      rst_n = 1'b1;
      m_reset();
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.decode_en = 1'b0; bus.reg_addr = 4'h0; bus.cpu_data = 8'h00;
      bus.sst = '0;
      m_reset();
      #12 rst_n = 1'b1;
      cyc();
      test_reset();
      test_revb();
      test_latch0();
      test_filter();
      test_acclaim();
      test_conflicts();
      test_random();
      test_sst_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
